// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixup in a final FIX cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic               isdiv_q, isdiv_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dzo_q, dzo_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    signed_op = ~iOp[0];
    a_neg     = signed_op & iA[WIDTH-1];
    b_neg     = signed_op & iB[WIDTH-1];
    a_mag     = a_neg ? -iA : iA;
    b_mag     = b_neg ? -iB : iB;
    // acc holds {partial product, remaining multiplier bits} during MUL
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
    // acc holds {partial remainder, dividend/quotient bits} during DIV
    div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_sh - {1'b0, m_q};
    div_ge    = (div_sh >= {1'b0, m_q});
    prod_fix  = qneg_q ? -acc_q : acc_q;
    q_fix     = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    isdiv_d = isdiv_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart && !iFlush) begin
          case (iOp)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              m_d     = iOp[1] ? b_mag : a_mag;
              acc_d   = {{WIDTH{1'b0}}, (iOp[1] ? a_mag : b_mag)};
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              isdiv_d = iOp[1];
              dz_d    = (iB == '0);
              cnt_d   = '0;
              state_d = iOp[1] ? S_DIV : S_MUL;
            end
            3'b100: begin
              hi_d   = iA;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = iA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (isdiv_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dzo_d   = isdiv_q & dz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush cancels everything in flight, including the FIX write-back
    if (iFlush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dzo_d   = 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end

  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = done_q;
  assign oDivZero = dzo_q;
  assign oHi      = hi_q;
  assign oLo      = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32): arithmetic results, latency, flush, reset.
module tb_mdu_iter;
  logic        iClk = 1'b0;
  logic        iRst, iStart, iFlush;
  logic [2:0]  iOp;
  logic [31:0] iA, iB;
  logic        oBusy, oDone, oDivZero;
  logic [31:0] oHi, oLo;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iFlush(iFlush), .oBusy(oBusy), .oDone(oDone), .oDivZero(oDivZero),
    .oHi(oHi), .oLo(oLo)
  );

  always #5 iClk = ~iClk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge iClk); #1;
  endtask

  // Issue one op and wait for oDone; lat = edges after the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    step();
    iStart = 1'b0;
    lat = 0; busy_cyc = 0;
    while (!oDone && lat < 100) begin
      if (oBusy) busy_cyc++;
      step();
      lat++;
    end
    if (lat >= 100) begin
      errors++;
      $display("FAIL timeout op=%0d: no oDone within 100 edges", op);
    end
  endtask

  task automatic test_reset();
    checks++; if (oBusy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", oBusy); end
    checks++; if (oDone !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", oDone); end
    checks++; if (oDivZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", oDivZero); end
    checks++; if (oHi !== 32'h0)     begin errors++; $display("FAIL reset_hi got %h exp 0", oHi); end
    checks++; if (oLo !== 32'h0)     begin errors++; $display("FAIL reset_lo got %h exp 0", oLo); end
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(3'b000, 32'hFFFFFFFD, 32'h00000005, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (bc !== 33)  begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", bc); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b exp 0", oBusy); end
    checks++; if (oHi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp FFFFFFFF", oHi); end
    checks++; if (oLo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp FFFFFFF1", oLo); end
    checks++; if (oDivZero !== 1'b0) begin errors++; $display("FAIL mult_dz got %b exp 0", oDivZero); end
    step();
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", oDone); end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if (oHi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp FFFFFFFE", oHi); end
    checks++; if (oLo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", oLo); end
    step();
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (oLo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp FFFFFFFD", oLo); end
    checks++; if (oHi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp FFFFFFFF", oHi); end
    step();
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (oLo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", oLo); end
    checks++; if (oHi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", oHi); end
    checks++; if (oDivZero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got %b exp 0", oDivZero); end
    step();
  endtask

  task automatic test_divzero();
    int lat, bc;
    run_op(3'b011, 32'h00000007, 32'h0, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divz_latency got %0d exp 33", lat); end
    checks++; if (oLo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h exp FFFFFFFF", oLo); end
    checks++; if (oHi !== 32'h00000007) begin errors++; $display("FAIL divz_hi got %h exp 00000007", oHi); end
    checks++; if (oDivZero !== 1'b1) begin errors++; $display("FAIL divz_flag got %b exp 1", oDivZero); end
    step();
    checks++; if (oDivZero !== 1'b0) begin errors++; $display("FAIL divz_flag_clear got %b exp 0", oDivZero); end
  endtask

  task automatic test_mthi();
    iOp = 3'b100; iA = 32'hCAFEBABE; iStart = 1'b1;
    step();
    iStart = 1'b0;
    checks++; if (oDone !== 1'b1) begin errors++; $display("FAIL mthi_done got %b exp 1", oDone); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", oBusy); end
    checks++; if (oHi !== 32'hCAFEBABE) begin errors++; $display("FAIL mthi_hi got %h exp CAFEBABE", oHi); end
    checks++; if (oLo !== 32'hFFFFFFFF) begin errors++; $display("FAIL mthi_lo_kept got %h exp FFFFFFFF", oLo); end
    step();
  endtask

  // MULT in flight: DIV start at cycle 5 ignored, flush at cycle 10.
  task automatic test_busy_flush();
    bit seen_done = 0;
    iOp = 3'b000; iA = 32'h2; iB = 32'h3; iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (4) step();
    iOp = 3'b010; iA = 32'h9; iB = 32'h3; iStart = 1'b1;
    step();
    iStart = 1'b0;
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL busy_ignore got %b exp 1", oBusy); end
    repeat (4) step();
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", oBusy); end
    checks++; if (oHi !== 32'hCAFEBABE) begin errors++; $display("FAIL flush_hi got %h exp CAFEBABE", oHi); end
    checks++; if (oLo !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_lo got %h exp FFFFFFFF", oLo); end
    for (int i = 0; i < 40; i++) begin
      if (oDone || oBusy) seen_done = 1;
      step();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL flush_no_done got %b exp 0", seen_done); end
  endtask

  task automatic test_mtlo();
    iOp = 3'b101; iA = 32'h12345678; iStart = 1'b1;
    step();
    iStart = 1'b0;
    checks++; if (oDone !== 1'b1) begin errors++; $display("FAIL mtlo_done got %b exp 1", oDone); end
    checks++; if (oLo !== 32'h12345678) begin errors++; $display("FAIL mtlo_lo got %h exp 12345678", oLo); end
    checks++; if (oHi !== 32'hCAFEBABE) begin errors++; $display("FAIL mtlo_hi_kept got %h exp CAFEBABE", oHi); end
    step();
  endtask

  // Flush landing on the FIX edge must suppress the write-back.
  task automatic test_flush_fix();
    iOp = 3'b001; iA = 32'h5; iB = 32'h7; iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (32) step();
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL fix_busy got %b exp 1", oBusy); end
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL fix_flush_done got %b exp 0", oDone); end
    checks++; if (oLo !== 32'h12345678) begin errors++; $display("FAIL fix_flush_lo got %h exp 12345678", oLo); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL fix_flush_busy got %b exp 0", oBusy); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(3'b001, 32'h2, 32'h3, lat, bc);
    checks++; if (oLo !== 32'h6) begin errors++; $display("FAIL b2b_first_lo got %h exp 6", oLo); end
    run_op(3'b001, 32'h4, 32'h5, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat); end
    checks++; if (oLo !== 32'd20) begin errors++; $display("FAIL b2b_lo got %h exp 14", oLo); end
    checks++; if (oHi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %h exp 0", oHi); end
    step();
  endtask

  task automatic test_illegal();
    iOp = 3'b110; iA = 32'hDEADBEEF; iStart = 1'b1;
    step();
    iStart = 1'b0;
    checks++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++; $display("FAIL illegal_op got busy=%b done=%b exp 0 0", oBusy, oDone); end
    checks++; if (oHi !== 32'h0 || oLo !== 32'd20) begin
      errors++; $display("FAIL illegal_regs got %h/%h exp 0/14", oHi, oLo); end
    step();
  endtask

  task automatic test_reset_mid();
    iOp = 3'b010; iA = 32'h64; iB = 32'h7; iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (5) step();
    iRst = 1'b1;
    #1;
    checks++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oDivZero !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b%b%b exp 000", oBusy, oDone, oDivZero); end
    checks++; if (oHi !== 32'h0 || oLo !== 32'h0) begin
      errors++; $display("FAIL rst_mid_regs got %h/%h exp 0/0", oHi, oLo); end
    step();
    iRst = 1'b0;
    repeat (40) step();
    checks++; if (oDone !== 1'b0 || oLo !== 32'h0) begin
      errors++; $display("FAIL rst_mid_after got done=%b lo=%h exp 0/0", oDone, oLo); end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iFlush = 1'b0; iOp = 3'b000; iA = '0; iB = '0;
    repeat (2) step();
    test_reset();
    iRst = 1'b0;
    step();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_mthi();
    test_busy_flush();
    test_mtlo();
    test_flush_fix();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the combinational ALU in the multicycle datapath.
- Executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles, plus single-cycle MTHI and MTLO.
- Uses a start/busy/done handshake so the control FSM can stall while an operation is in progress.
- Supports a synchronous flush so an exception can cancel an in-flight operation.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits; must be at least 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  reset, asynchronous and active-high.
- iStart  in  1  request; accepted only when oBusy=0 and iOp is legal.
- iOp  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are illegal and are ignored.
- iA  in  WIDTH  multiplicand / dividend / MTHI and MTLO source.
- iB  in  WIDTH  multiplier / divisor.
- iFlush  in  1  synchronous cancel of the in-flight operation.
- oBusy  out  1  an operation is in progress.
- oDone  out  1  one-cycle pulse; HI/LO have just been updated.
- oDivZero  out  1  valid while oDone=1; the completed DIV/DIVU had iB=0.
- oHi  out  WIDTH  HI register.
- oLo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE; oBusy, oDone and oDivZero = 0; oHi and oLo = 0; counter = 0. Reset asserted mid-operation aborts it immediately.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - On iStart with a MULT/MULTU/DIV/DIVU code: latch operands at edge E0.
  - For signed ops, latch |iA| and |iB|, and record the result signs (quotient sign = sign A XOR sign B; remainder sign = sign A).
  - Go to MUL or DIV; oBusy=1 from E0.
- IDLE, MTHI/MTLO: HI (or LO) ← iA at E0; oDone=1 for the following cycle; oBusy stays 0; state stays IDLE.
- MUL: shift-add radix-2, one multiplier bit per cycle, for WIDTH cycles (E1..E_WIDTH), then go to FIX.
- DIV: restoring division, one quotient bit per cycle, for WIDTH cycles, then go to FIX.
- FIX: at edge E(WIDTH+1):
  - Apply sign correction and write HI/LO.
  - oDone=1 and oBusy=0 for the following cycle; return to IDLE.
  - Total latency from accept to oDone is WIDTH+1 edges.
- Product: the 2·WIDTH-bit result; HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative ÷ -1: LO = most-negative (wraps), HI = 0; no error flag.
- Divide by zero:
  - Full latency is still used.
  - Unsigned: LO = all ones, HI = dividend.
  - Signed: apply the normal sign fixup to that magnitude result.
  - oDivZero=1 with oDone.
- iStart while oBusy=1: ignored; no queuing.
- Illegal iOp: ignored; no state change and no oDone.
- iFlush=1 while busy:
  - Return to IDLE at the next edge with oBusy=0.
  - HI/LO unchanged; no oDone pulse.
- iFlush in IDLE: suppresses any iStart in the same cycle.
- iFlush and the FIX edge in the same cycle: the flush wins; HI/LO are not written.
- oHi/oLo are held stable throughout MUL/DIV; only their final values are ever written. Intermediate partial products and remainders live in internal registers.
- A back-to-back iStart in the cycle where oDone=1 is accepted; that cycle has oBusy=0.

Test Plan (WIDTH=32):
- MULT iA=FFFFFFFD (-3), iB=00000005 → oDone exactly 33 edges after accept; oHi=FFFFFFFF, oLo=FFFFFFF1; oBusy high for 33 cycles.
- MULTU iA=FFFFFFFF, iB=FFFFFFFF → oHi=FFFFFFFE, oLo=00000001.
- DIV iA=FFFFFFF9 (-7), iB=00000002 → oLo=FFFFFFFD, oHi=FFFFFFFF.
- DIV iA=80000000, iB=FFFFFFFF → oLo=80000000, oHi=0, oDivZero=0.
- DIVU iA=00000007, iB=0 → oLo=FFFFFFFF, oHi=00000007, oDivZero=1.
- MULT in progress:
  - iStart DIV at cycle 5 → ignored.
  - iFlush at cycle 10 → oBusy=0 next cycle, no oDone, HI/LO keep their prior values.
  - Then MTLO iA=12345678 → oLo=12345678, oDone after 1 edge.
  - Then iRst during a DIV → all outputs 0 immediately.
